// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
// 2-flop input synchroniser, 3-sample majority per bit, false-start
// rejection, parity/framing error flags, valid/ready output with overrun pulse.
// Optional break detection is compiled in with `define UART_RX_BREAK_DETECT_EN.
module uart_rx_param #(
    parameter int ClocksPerBaud = 8,
    parameter int DataBits      = 8,
    parameter int ParityMode    = 0,
    parameter int StopBits      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_in,
    output logic [DataBits-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_parity_err,
    output logic                rx_frame_err,
    output logic                rx_overrun,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                rx_break,
`endif
    output logic                rx_busy
);

    localparam int M  = ClocksPerBaud / 2;
    localparam int CW = $clog2(ClocksPerBaud);
    localparam int IW = $clog2(DataBits);

    localparam logic [CW-1:0] S0_AT = CW'(M - 1);
    localparam logic [CW-1:0] S1_AT = CW'(M);
    localparam logic [CW-1:0] S2_AT = CW'(M + 1);
    localparam logic [CW-1:0] LAST  = CW'(ClocksPerBaud - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic [IW-1:0]         bidx_q, bidx_d;
    logic                  sidx_q, sidx_d;
    logic [DataBits-1:0]   shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;

    logic [DataBits-1:0]   data_q;
    logic                  valid_q, operr_q, oferr_q, ovr_q;

    logic                  line, maj, at_s0, at_s1, at_s2, cnt_end;
    logic                  done, done_ferr;
    logic                  brk_block, is_brk;

    assign line    = sync2_q;
    assign maj     = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);
    assign at_s0   = (cnt_q == S0_AT);
    assign at_s1   = (cnt_q == S1_AT);
    assign at_s2   = (cnt_q == S2_AT);
    assign cnt_end = (cnt_q == LAST);

    // Synchroniser and receive FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            bidx_q  <= '0;
            sidx_q  <= 1'b0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            bidx_q  <= bidx_d;
            sidx_q  <= sidx_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic          pbit_q, pbit_d;
    logic          brk_q;
    logic [CW-1:0] brk_cnt_q;
    assign brk_block = brk_q;
    assign is_brk    = (shreg_q == '0) && !pbit_q && done_ferr;
    assign rx_break  = brk_q;

    // Received parity bit (break needs it 0) and break hold/release timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pbit_q    <= 1'b0;
            brk_q     <= 1'b0;
            brk_cnt_q <= '0;
        end else begin
            pbit_q <= pbit_d;
            if (done && is_brk) begin
                brk_q     <= 1'b1;
                brk_cnt_q <= '0;
            end else if (brk_q) begin
                if (!line) begin
                    brk_cnt_q <= '0;
                end else if (brk_cnt_q == LAST) begin
                    brk_q     <= 1'b0;
                    brk_cnt_q <= '0;
                end else begin
                    brk_cnt_q <= brk_cnt_q + 1'b1;
                end
            end
        end
    end
`else
    assign brk_block = 1'b0;
    assign is_brk    = 1'b0;
`endif

    // Next-state logic: bit timing, majority sampling and frame assembly
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_end ? '0 : cnt_q + 1'b1;
        armed_d   = armed_q;
        s0_d      = at_s0 ? line : s0_q;
        s1_d      = at_s1 ? line : s1_q;
        bidx_d    = bidx_q;
        sidx_d    = sidx_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        done      = 1'b0;
        done_ferr = ferr_q;
`ifdef UART_RX_BREAK_DETECT_EN
        pbit_d    = pbit_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                // Only a high line seen since entering IDLE arms the detector
                armed_d = (armed_q | line) & ~brk_block;
                if (armed_q && !line && !brk_block) begin
                    state_d = START;
                    armed_d = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    pbit_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (at_s2 && maj) begin
                    state_d = IDLE;
                end else if (cnt_end) begin
                    state_d = DATA;
                    bidx_d  = '0;
                end
            end
            DATA: begin
                if (at_s2) shreg_d = {maj, shreg_q[DataBits-1:1]};
                if (cnt_end) begin
                    if (bidx_q == IW'(DataBits - 1)) begin
                        state_d = (ParityMode != 0) ? PARITY : STOP;
                        sidx_d  = 1'b0;
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (at_s2) begin
                    perr_d = (ParityMode == 2) ? ~(^shreg_q ^ maj) : (^shreg_q ^ maj);
`ifdef UART_RX_BREAK_DETECT_EN
                    pbit_d = maj;
`endif
                end
                if (cnt_end) begin
                    state_d = STOP;
                    sidx_d  = 1'b0;
                end
            end
            STOP: begin
                if (at_s2) begin
                    ferr_d = ferr_q | ~maj;
                    // Finish on the last stop sample; don't wait out the period
                    if (sidx_q == 1'(StopBits - 1)) begin
                        done      = 1'b1;
                        done_ferr = ferr_q | ~maj;
                        state_d   = IDLE;
                    end
                end
                if (cnt_end && !done) sidx_d = sidx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output holding register with valid/ready handshake and overrun pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            operr_q <= 1'b0;
            oferr_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done && !is_brk) begin
                if (!valid_q || rx_ready) begin
                    data_q  <= shreg_q;
                    operr_q <= perr_q;
                    oferr_q <= done_ferr;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = operr_q;
    assign rx_frame_err  = oferr_q;
    assign rx_overrun    = ovr_q;
    assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 7E1, 8N2) at 8 clk/bit.
module tb_uart_rx_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: 8N1
    logic       rx_a, rdy_a, vld_a, perr_a, ferr_a, ovr_a, busy_a;
    logic [7:0] data_a;
    // B: 7 data bits, even parity
    logic       rx_b, rdy_b, vld_b, perr_b, ferr_b, ovr_b, busy_b;
    logic [6:0] data_b;
    // C: 8 data bits, 2 stop bits
    logic       rx_c, rdy_c, vld_c, perr_c, ferr_c, ovr_c, busy_c;
    logic [7:0] data_c;

    uart_rx_param #(.ClocksPerBaud(8)) u_a (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_a), .rx_data(data_a), .rx_valid(vld_a),
        .rx_ready(rdy_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a),
        .rx_overrun(ovr_a), .rx_busy(busy_a));

    uart_rx_param #(.ClocksPerBaud(8), .DataBits(7), .ParityMode(1)) u_b (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_b), .rx_data(data_b), .rx_valid(vld_b),
        .rx_ready(rdy_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b),
        .rx_overrun(ovr_b), .rx_busy(busy_b));

    uart_rx_param #(.ClocksPerBaud(8), .StopBits(2)) u_c (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_c), .rx_data(data_c), .rx_valid(vld_c),
        .rx_ready(rdy_c), .rx_parity_err(perr_c), .rx_frame_err(ferr_c),
        .rx_overrun(ovr_c), .rx_busy(busy_c));

    int ovr_cnt_a = 0;
    always @(negedge clk) if (ovr_a) ovr_cnt_a++;

    // Drive n frame bits (LSB first) on instance d, 8 cycles each, from a negedge
    task automatic send(input int d, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            case (d)
                0:       rx_a = bits[i];
                1:       rx_b = bits[i];
                default: rx_c = bits[i];
            endcase
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL rst_vld_a got %b exp 0", vld_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL rst_data_a got %h exp 00", data_a); end
        checks++; if ({perr_a, ferr_a, ovr_a} !== 3'b000) begin errors++; $display("FAIL rst_flags_a got %b exp 000", {perr_a, ferr_a, ovr_a}); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy_a got %b exp 0", busy_a); end
        checks++; if ({vld_b, vld_c} !== 2'b00) begin errors++; $display("FAIL rst_vld_bc got %b exp 00", {vld_b, vld_c}); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        rdy_a = 1'b1;
        send(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL basic_early got %b exp 0", vld_a); end
        @(negedge clk);
        checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL basic_vld got %b exp 1", vld_a); end
        checks++; if (data_a !== 8'h55) begin errors++; $display("FAIL basic_data got %h exp 55", data_a); end
        checks++; if ({perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b exp 00", {perr_a, ferr_a}); end
        @(negedge clk);
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL basic_drop got %b exp 0", vld_a); end
    endtask

    task automatic test_parity;
        logic got;
        rdy_b = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send(1, {6'b0, 1'b1, 1'(k), 7'h3A, 1'b0}, 10);
            got = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (vld_b) begin got = 1'b1; break; end
                @(negedge clk);
            end
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL par_vld%0d got %b exp 1", k, got); end
            checks++; if (data_b !== 7'h3A) begin errors++; $display("FAIL par_data%0d got %h exp 3a", k, data_b); end
            checks++; if (perr_b !== 1'(k)) begin errors++; $display("FAIL par_err%0d got %b exp %0d", k, perr_b, k); end
            @(negedge clk);
        end
    endtask

    task automatic test_glitch;
        int seen;
        logic got;
        rdy_a = 1'b1;
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        seen = 0;
        repeat (20) begin @(negedge clk); if (vld_a) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL glitch_vld got %0d exp 0", seen); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy_a); end
        send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (vld_a) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL glitch_next_vld got %b exp 1", got); end
        checks++; if (data_a !== 8'hA5) begin errors++; $display("FAIL glitch_next_data got %h exp a5", data_a); end
        @(negedge clk);
    endtask

    task automatic test_overrun;
        int c0, seen;
        rdy_a = 1'b0;
        c0 = ovr_cnt_a;
        send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        repeat (2) @(negedge clk);
        checks++; if (vld_a !== 1'b1 || data_a !== 8'h11) begin errors++; $display("FAIL ovr_first got %b/%h exp 1/11", vld_a, data_a); end
        send(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
        repeat (4) @(negedge clk);
        checks++; if (ovr_cnt_a - c0 != 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt_a - c0); end
        checks++; if (data_a !== 8'h11) begin errors++; $display("FAIL ovr_held got %h exp 11", data_a); end
        checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL ovr_vld got %b exp 1", vld_a); end
        rdy_a = 1'b1;
        @(negedge clk);
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL ovr_accept got %b exp 0", vld_a); end
        seen = 0;
        repeat (20) begin @(negedge clk); if (vld_a) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL ovr_no_second got %0d exp 0", seen); end
    endtask

    task automatic test_stop2;
        logic got;
        int busy_seen;
        rdy_c = 1'b1;
        send(2, {5'b0, 1'b0, 1'b1, 8'h6B, 1'b0}, 11);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (vld_c) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL stop2_vld got %b exp 1", got); end
        checks++; if (ferr_c !== 1'b1) begin errors++; $display("FAIL stop2_ferr got %b exp 1", ferr_c); end
        checks++; if (data_c !== 8'h6B) begin errors++; $display("FAIL stop2_data got %h exp 6b", data_c); end
        busy_seen = 0;
        repeat (30) begin @(negedge clk); if (busy_c || vld_c) busy_seen++; end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL stop2_rearm got %0d exp 0", busy_seen); end
        rx_c = 1'b1;
        repeat (3) @(negedge clk);
        send(2, {5'b0, 2'b11, 8'h3C, 1'b0}, 11);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (vld_c) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (got !== 1'b1 || data_c !== 8'h3C) begin errors++; $display("FAIL stop2_next got %b/%h exp 1/3c", got, data_c); end
        checks++; if (ferr_c !== 1'b0) begin errors++; $display("FAIL stop2_next_ferr got %b exp 0", ferr_c); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic got;
        rdy_a = 1'b0;
        send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        repeat (2) @(negedge clk);
        checks++; if (vld_a !== 1'b1 || data_a !== 8'h5A) begin errors++; $display("FAIL mid_held got %b/%h exp 1/5a", vld_a, data_a); end
        send(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 4);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (vld_a !== 1'b0 || data_a !== 8'h00) begin errors++; $display("FAIL mid_rst_out got %b/%h exp 0/00", vld_a, data_a); end
        checks++; if ({busy_a, perr_a, ferr_a, ovr_a} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags got %b exp 0000", {busy_a, perr_a, ferr_a, ovr_a}); end
        rx_a = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rdy_a = 1'b1;
        send(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (vld_a) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (got !== 1'b1 || data_a !== 8'hC3) begin errors++; $display("FAIL mid_next got %b/%h exp 1/c3", got, data_a); end
        checks++; if ({perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL mid_next_flags got %b exp 00", {perr_a, ferr_a}); end
    endtask

    initial begin
        rst_n = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        #2 rst_n = 1'b0;
        test_reset;
        test_basic;
        test_parity;
        test_glitch;
        test_overrun;
        test_stop2;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
